// File: rtl/trace_accum_engine_pkg.sv
// trace_accum_engine_pkg: shared state encoding, width helpers and saturating add
package trace_accum_engine_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;
  function automatic int addr_w(input int nr, input int nc);
    return (nr * nc > 1) ? $clog2(nr * nc) : 1;
  endfunction
  function automatic int col_w(input int nc);
    return $clog2(nc + 1);
  endfunction
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [63:0] s, hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction
endpackage

// File: rtl/trace_accum_engine_if.sv
// trace_accum_engine_if: job control, RAM read and result handshake bundle
interface trace_accum_engine_if
  import trace_accum_engine_pkg::*;
#(
  parameter int N = 16,
  parameter int ACC_WIDTH = 32,
  parameter int NR = 4,
  parameter int NC = 2
);
  localparam int ADDR_W = addr_w(NR, NC);
  localparam int COL_W = col_w(NC);
  logic start;
  logic [COL_W-1:0] num_cols;
  logic conj_en;
  logic busy;
  logic rd_en;
  logic [ADDR_W-1:0] y_rd_addr, g_rd_addr;
  logic signed [N-1:0] y_rd_data_r, y_rd_data_i, g_rd_data_r, g_rd_data_i;
  logic result_valid, result_ready;
  logic signed [ACC_WIDTH-1:0] trace_r, trace_i;
  logic ovf;
  modport master (
    output start, num_cols, conj_en, y_rd_data_r, y_rd_data_i, g_rd_data_r, g_rd_data_i, result_ready,
    input busy, rd_en, y_rd_addr, g_rd_addr, result_valid, trace_r, trace_i, ovf
  );
  modport slave (
    input start, num_cols, conj_en, y_rd_data_r, y_rd_data_i, g_rd_data_r, g_rd_data_i, result_ready,
    output busy, rd_en, y_rd_addr, g_rd_addr, result_valid, trace_r, trace_i, ovf
  );
endinterface

// File: rtl/trace_accum_engine_cmac_sat_pipe.sv
// trace_accum_engine_cmac_sat_pipe: conj/multiply/shift stage feeding a saturating complex accumulator
module trace_accum_engine_cmac_sat_pipe
  import trace_accum_engine_pkg::*;
#(
  parameter int N = 16,
  parameter int Q = 8,
  parameter int ACC_WIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic conj_en,
  input  logic vin,
  input  logic signed [N-1:0] y_r,
  input  logic signed [N-1:0] y_i,
  input  logic signed [N-1:0] g_r,
  input  logic signed [N-1:0] g_i,
  output logic signed [ACC_WIDTH-1:0] acc_r,
  output logic signed [ACC_WIDTH-1:0] acc_i,
  output logic ovf,
  output logic active
);
  localparam int PW = 2 * N + 1;
  logic [RD_LAT-1:0] tag;
  logic prod_v, hit;
  logic signed [PW-1:0] yr, yi, gr, gi, mul_r, mul_i, prod_r, prod_i;
  logic signed [63:0] sum_r, sum_i;
  assign active = |tag || prod_v;
  // full-width complex product and the saturated next accumulator value
  always_comb begin
    yr = PW'(y_r);
    yi = PW'(y_i);
    gr = PW'(g_r);
    gi = PW'(g_i);
    mul_r = conj_en ? yr * gr + yi * gi : yr * gr - yi * gi;
    mul_i = conj_en ? yr * gi - yi * gr : yr * gi + yi * gr;
    sum_r = sat_add(64'(acc_r), 64'(prod_r), ACC_WIDTH);
    sum_i = sat_add(64'(acc_i), 64'(prod_i), ACC_WIDTH);
    hit = (sum_r != 64'(acc_r) + 64'(prod_r)) || (sum_i != 64'(acc_i) + 64'(prod_i));
  end
  // valid tag tracks RAM latency; stage A registers the scaled product, stage B accumulates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag <= '0;
      prod_v <= 1'b0;
      prod_r <= '0;
      prod_i <= '0;
      acc_r <= '0;
      acc_i <= '0;
      ovf <= 1'b0;
    end else begin
      tag <= RD_LAT'({tag, vin});
      prod_v <= tag[RD_LAT-1];
      if (tag[RD_LAT-1]) begin
        prod_r <= mul_r >>> Q;
        prod_i <= mul_i >>> Q;
      end
      if (clr) begin
        acc_r <= '0;
        acc_i <= '0;
        ovf <= 1'b0;
      end else if (prod_v) begin
        acc_r <= sum_r[ACC_WIDTH-1:0];
        acc_i <= sum_i[ACC_WIDTH-1:0];
        ovf <= ovf | hit;
      end
    end
  end
endmodule

// File: rtl/trace_accum_engine.sv
// trace_accum_engine: trace(Y^H*G) or trace(Y^T*G) job engine over pipelined Y/G RAM reads
module trace_accum_engine
  import trace_accum_engine_pkg::*;
#(
  parameter int N = 16,
  parameter int Q = 8,
  parameter int ACC_WIDTH = 32,
  parameter int NR = 4,
  parameter int NC = 2,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  trace_accum_engine_if.slave bus
);
  localparam int ADDR_W = addr_w(NR, NC);
  localparam int COL_W = col_w(NC);
  localparam int CNT_W = ADDR_W > COL_W ? ADDR_W : COL_W;
  state_t state, nxt;
  logic [CNT_W-1:0] k, j, cols;
  logic [COL_W-1:0] eff_cols;
  logic conj, accept, last_col, last, pipe_active, pipe_ovf;
  logic signed [ACC_WIDTH-1:0] acc_r, acc_i;
  assign eff_cols = (bus.num_cols == '0 || bus.num_cols > COL_W'(NC)) ? COL_W'(NC) : bus.num_cols;
  assign accept = state == IDLE && bus.start;
  assign last_col = j == cols - 1'b1;
  assign last = last_col && k == CNT_W'(NR - 1);
  assign bus.busy = state != IDLE;
  assign bus.rd_en = state == ISSUE;
  assign bus.result_valid = state == HOLD;
  assign bus.y_rd_addr = ADDR_W'(int'(k) * NC + int'(j));
  assign bus.g_rd_addr = bus.y_rd_addr;
  // job sequencing: issue reads, drain the pipe, hold the result until accepted
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? ISSUE : IDLE;
      ISSUE:   nxt = last ? DRAIN : ISSUE;
      DRAIN:   nxt = pipe_active ? DRAIN : HOLD;
      HOLD:    nxt = bus.result_ready ? IDLE : HOLD;
      default: nxt = IDLE;
    endcase
  end
  // state, job settings, row/column counters and the held result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      j <= '0;
      cols <= '0;
      conj <= 1'b0;
      bus.trace_r <= '0;
      bus.trace_i <= '0;
      bus.ovf <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        cols <= CNT_W'(eff_cols);
        conj <= bus.conj_en;
      end
      if (state == ISSUE) begin
        j <= last_col ? '0 : j + 1'b1;
        k <= last ? '0 : last_col ? k + 1'b1 : k;
      end
      if (state == DRAIN && !pipe_active) begin
        bus.trace_r <= acc_r;
        bus.trace_i <= acc_i;
        bus.ovf <= pipe_ovf;
      end
    end
  end
  trace_accum_engine_cmac_sat_pipe #(.N(N), .Q(Q), .ACC_WIDTH(ACC_WIDTH), .RD_LAT(RD_LAT)) u_pipe (
    .clk(clk),
    .rst_n(rst_n),
    .clr(accept),
    .conj_en(conj),
    .vin(bus.rd_en),
    .y_r(bus.y_rd_data_r),
    .y_i(bus.y_rd_data_i),
    .g_r(bus.g_rd_data_r),
    .g_i(bus.g_rd_data_i),
    .acc_r(acc_r),
    .acc_i(acc_i),
    .ovf(pipe_ovf),
    .active(pipe_active)
  );
endmodule
